// File: rtl/ctrl_bridge.sv
// Byte-stream to Wishbone B4 classic bridge.
// Framed commands drive one bus cycle; each frame ends in a status byte.
module ctrl_bridge #(
  parameter int ADR_W   = 16,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [ADR_W-1:0]   wb_adr_o,
  output logic [DAT_W-1:0]   wb_dat_o,
  output logic [DAT_W/8-1:0] wb_sel_o,
  input  logic [DAT_W-1:0]   wb_dat_i,
  input  logic               wb_ack_i,
  input  logic               wb_err_i,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_valid_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o
);

  localparam int ADR_B = ADR_W / 8;
  localparam int DAT_B = DAT_W / 8;
  localparam int NB_MX = (ADR_B > DAT_B) ? ADR_B : DAT_B;
  localparam int CNT_W = $clog2(NB_MX + 1);
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WAIT,
    S_STATUS,
    S_RDATA
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   dat_q, dat_d;
  logic [DAT_W-1:0]   rdat_q, rdat_d;
  logic [1:0]         status_q, status_d;

  logic last_adr;
  logic last_dat;
  logic expire;

  assign last_adr = (cnt_q == CNT_W'(ADR_B - 1));
  assign last_dat = (cnt_q == CNT_W'(DAT_B - 1));
  assign expire   = (TIMEOUT != 0) &&
                    (int'(timer_q) == TIMEOUT - 1);

  // State register and datapath flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      timer_q  <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      rdat_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      rdat_q   <= rdat_d;
      status_q <= status_d;
    end
  end

  // Frame parser, bus-cycle control and timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    rdat_d   = rdat_q;
    status_d = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid_i && rx_data_i[6:0] == 7'd0) begin
          we_d    = rx_data_i[7];
          cnt_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_valid_i) begin
          adr_d = (adr_q << 8) | ADR_W'(rx_data_i);
          cnt_d = cnt_q + CNT_W'(1);
          if (last_adr) begin
            cnt_d = '0;
            if (we_q) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_WAIT;
              cyc_d   = 1'b1;
              timer_d = '0;
            end
          end
        end
      end
      S_WDATA: begin
        if (rx_valid_i) begin
          dat_d = (dat_q << 8) | DAT_W'(rx_data_i);
          cnt_d = cnt_q + CNT_W'(1);
          if (last_dat) begin
            cnt_d   = '0;
            state_d = S_WAIT;
            cyc_d   = 1'b1;
            timer_d = '0;
          end
        end
      end
      S_WAIT: begin
        if (wb_ack_i || wb_err_i) begin
          status_d = wb_err_i ? 2'd3 : 2'd1;
          if (!wb_err_i && !we_q) begin
            rdat_d = wb_dat_i;
          end
          cyc_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_STATUS;
        end else if (expire) begin
          status_d = 2'd2;
          cyc_d    = 1'b0;
          cnt_d    = '0;
          state_d  = S_STATUS;
        end else if (TIMEOUT != 0) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_STATUS: begin
        if (rx_valid_i) begin
          cnt_d = '0;
          if (!we_q && status_q == 2'd1) begin
            state_d = S_RDATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RDATA: begin
        if (rx_valid_i) begin
          rdat_d = rdat_q << 8;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_dat) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // Reply byte depends only on registered state.
  always_comb begin
    tx_data_o = 8'h00;
    unique case (state_q)
      S_STATUS: tx_data_o = {6'd0, status_q};
      S_RDATA:  tx_data_o = rdat_q[DAT_W-1 -: 8];
      default:  tx_data_o = 8'h00;
    endcase
  end

  assign tx_valid_o = rx_valid_i;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = '1;

endmodule

// File: tb/tb_ctrl_bridge.sv
// Bench for ctrl_bridge: directed frames plus random frames
// against a frame-level reference model and a reactive slave.
module tb_ctrl_bridge;

  localparam int TO = 8;

  logic        clk;
  logic        rst_ni;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [15:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;

  int n_chk = 0;
  int n_err = 0;

  // slave configuration: 0 ack, 1 err, 2 silent, 3 ack+err
  int          s_mode = 2;
  int          s_delay = 0;
  logic [31:0] s_rdata = '0;
  logic        force_ack = 1'b0;

  // slave observations
  int          stb_len = 0;
  int          last_len = 0;
  int          starts = 0;
  int          unstable = 0;
  int          cyc_ne = 0;
  logic [15:0] cap_adr;
  logic [31:0] cap_dat;
  logic        cap_we;
  logic [3:0]  cap_sel;

  ctrl_bridge #(
    .ADR_W  (16),
    .DAT_W  (32),
    .TIMEOUT(TO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .rx_data_i (rx_data_i),
    .rx_valid_i(rx_valid_i),
    .tx_data_o (tx_data_o),
    .tx_valid_o(tx_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wishbone slave: responds on the (delay+1)-th strobe cycle.
  initial begin
    logic hit;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (wb_cyc_o !== wb_stb_o) cyc_ne++;
      if (wb_stb_o) begin
        if (stb_len == 0) begin
          starts++;
          cap_adr = wb_adr_o;
          cap_dat = wb_dat_o;
          cap_we  = wb_we_o;
          cap_sel = wb_sel_o;
        end else if (wb_adr_o !== cap_adr ||
                     wb_dat_o !== cap_dat ||
                     wb_we_o !== cap_we) begin
          unstable++;
        end
        stb_len++;
        hit = (stb_len == s_delay + 1);
        wb_ack_i = (hit && (s_mode == 0 || s_mode == 3))
                   || force_ack;
        wb_err_i = hit && (s_mode == 1 || s_mode == 3);
        wb_dat_i = wb_ack_i ? s_rdata : $urandom;
      end else begin
        if (stb_len != 0) last_len = stb_len;
        stb_len  = 0;
        wb_ack_i = force_ack;
        wb_err_i = 1'b0;
        wb_dat_i = $urandom;
      end
    end
  end

  task automatic xfer(input logic [7:0] b, output logic [7:0] r);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    #1;
    r = tx_data_o;
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
  endtask

  // Frame-level reference: outcome and strobe length from rules.
  task automatic run_frame(input logic we,
                           input logic [15:0] adr,
                           input logic [31:0] dat,
                           input int mode,
                           input int dly,
                           input logic [31:0] rd);
    logic [7:0] r;
    int exp_st;
    int exp_len;
    int s0;
    int n;
    s_mode   = mode;
    s_delay  = dly;
    s_rdata  = rd;
    s0       = starts;
    unstable = 0;
    if (mode == 2 || dly + 1 > TO) begin
      exp_st  = 2;
      exp_len = TO;
    end else begin
      exp_st  = (mode == 0) ? 1 : 3;
      exp_len = dly + 1;
    end
    xfer(we ? 8'h80 : 8'h00, r);
    check("cmd_tx", 32'(r), 0);
    for (int i = 0; i < 2; i++) begin
      xfer(adr[15-8*i -: 8], r);
      check("adr_tx", 32'(r), 0);
    end
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        xfer(dat[31-8*i -: 8], r);
        check("dat_tx", 32'(r), 0);
      end
    end
    r = 8'h00;
    n = 0;
    while (r == 8'h00 && n < 64) begin
      xfer(8'($urandom), r);
      n++;
    end
    check("status", 32'(r), 32'(exp_st));
    check("starts", 32'(starts - s0), 1);
    check("stb_len", 32'(last_len), 32'(exp_len));
    check("adr", 32'(cap_adr), 32'(adr));
    check("we", 32'(cap_we), 32'(we));
    check("sel", 32'(cap_sel), 32'hF);
    check("stable", 32'(unstable), 0);
    if (we) check("wdat", cap_dat, dat);
    if (!we && exp_st == 1) begin
      for (int i = 0; i < 4; i++) begin
        xfer(8'($urandom), r);
        check("rdat", 32'(r), 32'(rd[31-8*i -: 8]));
      end
    end
  endtask

  initial begin
    logic [7:0] r;
    int s0;
    int n;
    rst_ni     = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cyc", 32'(wb_cyc_o), 0);
    check("rst_stb", 32'(wb_stb_o), 0);
    check("rst_we", 32'(wb_we_o), 0);
    check("rst_adr", 32'(wb_adr_o), 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_tx", 32'(tx_data_o), 0);
    @(negedge clk);
    rst_ni = 1'b1;

    // directed frames
    run_frame(1'b1, 16'h1234, 32'hDEADBEEF, 0, 2, '0);
    run_frame(1'b0, 16'h0010, '0, 0, 1, 32'hCAFEF00D);
    run_frame(1'b0, 16'h0020, '0, 2, 0, '0);
    run_frame(1'b1, 16'h0004, 32'h1, 1, 0, '0);
    run_frame(1'b0, 16'h0044, '0, 0, 0, 32'h89ABCDEF);
    run_frame(1'b0, 16'h0050, '0, 0, TO - 1, 32'h5A5AA5A5);
    run_frame(1'b1, 16'h0060, 32'h77, 3, 3, '0);

    // reserved command is discarded
    s0 = starts;
    xfer(8'h41, r);
    check("rsv_tx", 32'(r), 0);
    repeat (4) @(negedge clk);
    check("rsv_nocyc", 32'(starts - s0), 0);
    run_frame(1'b1, 16'h1234, 32'hDEADBEEF, 0, 2, '0);

    // stray ack while idle
    s0 = starts;
    @(negedge clk);
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    check("stray_ack", 32'(starts - s0), 0);
    run_frame(1'b0, 16'h0070, '0, 0, 0, 32'h01020304);

    // reset during an active strobe
    s_mode = 2;
    xfer(8'h00, r);
    xfer(8'h00, r);
    xfer(8'h30, r);
    n = 0;
    while (!wb_stb_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stb_seen", 32'(wb_stb_o), 1);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_cyc", 32'(wb_cyc_o), 0);
    check("mid_rst_stb", 32'(wb_stb_o), 0);
    check("mid_rst_tx", 32'(tx_data_o), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    s0 = starts;
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    check("post_rst_nocyc", 32'(starts - s0), 0);
    run_frame(1'b1, 16'h4321, 32'h0BADF00D, 0, 0, '0);

    // random frames
    for (int k = 0; k < 40; k++) begin
      run_frame(1'($urandom),
                16'($urandom),
                $urandom,
                $urandom_range(0, 3),
                $urandom_range(0, 10),
                $urandom);
    end

    check("cyc_eq_stb", 32'(cyc_ne), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
